uart_mmio: RTL

UART_MMIO -- requirements
Module: uart_mmio

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_fifo.sv | 66 ++++++
 rtl/uart_mmio.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared state encoding and register offsets for uart_mmio  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam logic [3:0] TXDATA_OFS = 4'd0;
   localparam logic [3:0] STATUS_OFS = 4'd8;

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_fifo : byte-wide TX FIFO, push accepted when full if popping    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic          w_push;
   logic          w_pop;

   assign full  = (cnt_q == CNT_FULL);
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign dout  = mem_q[rd_q];

   // When full, a same-cycle pop frees the head slot, which the push then reuses.
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_q] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (w_push) begin
            wr_q <= wr_q + 1'b1;
         end
         if (w_pop) begin
            rd_q <= rd_q + 1'b1;
         end
         if (w_push && !w_pop) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (w_pop && !w_push) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_mmio : memory-mapped 8N1 UART transmitter with TX FIFO          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_mmio
   import uart_pkg::*;
#(
   parameter int               Nbits        = 64,
   parameter logic [Nbits-1:0] BASE         = Nbits'(64'h0000_0000_0000_1000),
   parameter int               CLKS_PER_BIT = 434,
   parameter int               DEPTH        = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             w_enable,
   input  logic             r_enable,
   input  logic [Nbits-1:0] addr,
   input  logic [Nbits-1:0] w_data,
   output logic [Nbits-1:0] r_data,
   output logic             sel,
   output logic             tx,
   output logic             irq_empty
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

   uart_state_e   state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          ovf_q;

   logic [Nbits-1:0] w_offs;
   logic [3:0]       w_reg;
   logic             w_push_req;
   logic             w_stat_rd;
   logic             w_pop;
   logic             w_last;
   logic [7:0]       w_dout;
   logic             w_full;
   logic             w_empty;
   logic [CW-1:0]    w_count;
   logic             w_unused;

   assign w_unused = ^w_data[Nbits-1:8];

   // Wrapping subtraction turns addresses below BASE into large offsets.
   assign w_offs     = addr - BASE;
   assign sel        = (w_offs[Nbits-1:4] == '0);
   assign w_reg      = w_offs[3:0];
   assign w_push_req = w_enable && sel && (w_reg == TXDATA_OFS);
   assign w_stat_rd  = r_enable && sel && (w_reg == STATUS_OFS);

   assign r_data = w_stat_rd
                 ? {{(Nbits-4){1'b0}}, ovf_q, (state_q != IDLE),
                    (w_count == '0), (w_count == CNT_FULL)}
                 : '0;

   assign tx        = tx_q;
   assign irq_empty = w_empty && (state_q == IDLE);
   assign w_last    = (baud_q == BAUD_LAST);

   uart_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push_req),
      .pop   (w_pop),
      .din   (w_data[7:0]),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      w_pop   = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (!w_empty) begin
               w_pop   = 1'b1;
               shift_d = w_dout;
               state_d = START;
            end
         end
         START: begin
            if (w_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (w_last) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end
            end
         end
         default: begin
            if (w_last) begin
               baud_d = '0;
               if (!w_empty) begin
                  w_pop   = 1'b1;
                  shift_d = w_dout;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
      endcase
   end

   // Line level is registered from the next state so it changes with the state edge.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         if (w_push_req && w_full && !w_pop) begin
            ovf_q <= 1'b1;
         end else if (w_stat_rd) begin
            ovf_q <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
